// File: rtl/axi_sram_arbiter_if.sv
// Bundle of N single-ID-width AXI4 channels (AR, R, AW, W, B).
// The arbiter uses one instance with N=NM for the masters and one with N=1, IDW=8 for the SRAM
// slave wrapper.
// Modports:
//   master - drives AR/AW/W requests and R/B readies (the initiator side)
//   slave  - drives AR/AW/W readies and R/B responses (the target side)
interface axi_sram_arbiter_if #(
    parameter int unsigned N   = 1,
    parameter int unsigned IDW = 4
);
    logic [N-1:0][IDW-1:0] arid;
    logic [N-1:0][31:0]    araddr;
    logic [N-1:0][3:0]     arlen;
    logic [N-1:0][2:0]     arsize;
    logic [N-1:0][1:0]     arburst;
    logic [N-1:0]          arvalid;
    logic [N-1:0]          arready;

    logic [N-1:0][IDW-1:0] rid;
    logic [N-1:0][31:0]    rdata;
    logic [N-1:0][1:0]     rresp;
    logic [N-1:0]          rlast;
    logic [N-1:0]          rvalid;
    logic [N-1:0]          rready;

    logic [N-1:0][IDW-1:0] awid;
    logic [N-1:0][31:0]    awaddr;
    logic [N-1:0][3:0]     awlen;
    logic [N-1:0][2:0]     awsize;
    logic [N-1:0][1:0]     awburst;
    logic [N-1:0]          awvalid;
    logic [N-1:0]          awready;

    logic [N-1:0][31:0]    wdata;
    logic [N-1:0][3:0]     wstrb;
    logic [N-1:0]          wlast;
    logic [N-1:0]          wvalid;
    logic [N-1:0]          wready;

    logic [N-1:0][IDW-1:0] bid;
    logic [N-1:0][1:0]     bresp;
    logic [N-1:0]          bvalid;
    logic [N-1:0]          bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_sram_arbiter.sv
// Shares a single-transaction AXI SRAM slave between NM masters. One master owns the slave for a
// whole transaction (AR + all R beats, or AW + all W beats + B). Round-robin between masters,
// read before write within one master. Channels are forwarded combinationally, no buffering.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   m          - master-side bundle (NM channels, IDW-bit IDs)
//   s          - slave-side bundle (1 channel, 8-bit IDs = {pad, master index, master ID})
//   grant      - one-hot granted master, 0 when idle
//   busy       - transaction in progress
//   prot_err   - sticky: LAST seen on a beat count that disagrees with the burst length
module axi_sram_arbiter #(
    parameter int unsigned NM  = 2,
    parameter int unsigned IDW = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    axi_sram_arbiter_if.slave   m,
    axi_sram_arbiter_if.master  s,
    output logic [NM-1:0]       grant,
    output logic                busy,
    output logic                prot_err
);
    localparam int unsigned IW = (NM > 1) ? $clog2(NM) : 1;

    typedef enum logic [2:0] {StIdle, StRaddr, StRdata, StWaddr, StWdata, StWresp} state_e;

    state_e          state_q;
    logic [NM-1:0]   grant_q;
    logic [IW-1:0]   gidx_q;
    logic [IW-1:0]   rr_last_q;
    logic [3:0]      len_q;
    logic [3:0]      cnt_q;
    logic            prot_err_q;

    logic [NM-1:0]   req;
    logic [IW-1:0]   win;
    logic            found;
    logic [1:0]      gidx2;

    assign req      = m.arvalid | m.awvalid;
    assign gidx2    = 2'(gidx_q);
    assign grant    = grant_q;
    assign busy     = (state_q != StIdle);
    assign prot_err = prot_err_q;

    // First requester after the last served master, wrapping modulo NM.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= int'(NM); k++) begin
            if (!found && req[(int'(rr_last_q) + k) % int'(NM)]) begin
                win   = IW'((int'(rr_last_q) + k) % int'(NM));
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            gidx_q     <= '0;
            rr_last_q  <= IW'(NM - 1);
            len_q      <= '0;
            cnt_q      <= '0;
            prot_err_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (found) begin
                        gidx_q       <= win;
                        grant_q      <= '0;
                        grant_q[win] <= 1'b1;
                        state_q      <= m.arvalid[win] ? StRaddr : StWaddr;
                    end
                end
                StRaddr: begin
                    if (s.arvalid[0] && s.arready[0]) begin
                        len_q   <= m.arlen[gidx_q];
                        cnt_q   <= '0;
                        state_q <= StRdata;
                    end
                end
                StRdata: begin
                    if (s.rvalid[0] && s.rready[0]) begin
                        cnt_q <= cnt_q + 4'd1;
                        if (s.rlast[0]) begin
                            // cnt_q still holds the index of this beat.
                            if (cnt_q != len_q) prot_err_q <= 1'b1;
                            rr_last_q <= gidx_q;
                            grant_q   <= '0;
                            state_q   <= StIdle;
                        end
                    end
                end
                StWaddr: begin
                    if (s.awvalid[0] && s.awready[0]) begin
                        len_q   <= m.awlen[gidx_q];
                        cnt_q   <= '0;
                        state_q <= StWdata;
                    end
                end
                StWdata: begin
                    if (s.wvalid[0] && s.wready[0]) begin
                        cnt_q <= cnt_q + 4'd1;
                        if (s.wlast[0]) begin
                            if (cnt_q != len_q) prot_err_q <= 1'b1;
                            state_q <= StWresp;
                        end
                    end
                end
                StWresp: begin
                    if (s.bvalid[0] && s.bready[0]) begin
                        rr_last_q <= gidx_q;
                        grant_q   <= '0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Channel routing: everything is zero unless the state owns that channel, so reset
    // (state = StIdle) silences all outputs immediately.
    always_comb begin
        m.arready = '0;
        m.awready = '0;
        m.wready  = '0;
        m.rid     = '0;
        m.rdata   = '0;
        m.rresp   = '0;
        m.rlast   = '0;
        m.rvalid  = '0;
        m.bid     = '0;
        m.bresp   = '0;
        m.bvalid  = '0;
        s.arid    = '0;
        s.araddr  = '0;
        s.arlen   = '0;
        s.arsize  = '0;
        s.arburst = '0;
        s.arvalid = '0;
        s.awid    = '0;
        s.awaddr  = '0;
        s.awlen   = '0;
        s.awsize  = '0;
        s.awburst = '0;
        s.awvalid = '0;
        s.wdata   = '0;
        s.wstrb   = '0;
        s.wlast   = '0;
        s.wvalid  = '0;
        s.rready  = '0;
        s.bready  = '0;
        case (state_q)
            StRaddr: begin
                s.arid[0]         = 8'({gidx2, m.arid[gidx_q]});
                s.araddr[0]       = m.araddr[gidx_q];
                s.arlen[0]        = m.arlen[gidx_q];
                s.arsize[0]       = m.arsize[gidx_q];
                s.arburst[0]      = m.arburst[gidx_q];
                s.arvalid[0]      = m.arvalid[gidx_q];
                m.arready[gidx_q] = s.arready[0];
            end
            StRdata: begin
                m.rid[gidx_q]    = s.rid[0][IDW-1:0];
                m.rdata[gidx_q]  = s.rdata[0];
                m.rresp[gidx_q]  = s.rresp[0];
                m.rlast[gidx_q]  = s.rlast[0];
                m.rvalid[gidx_q] = s.rvalid[0];
                s.rready[0]      = m.rready[gidx_q];
            end
            StWaddr: begin
                s.awid[0]         = 8'({gidx2, m.awid[gidx_q]});
                s.awaddr[0]       = m.awaddr[gidx_q];
                s.awlen[0]        = m.awlen[gidx_q];
                s.awsize[0]       = m.awsize[gidx_q];
                s.awburst[0]      = m.awburst[gidx_q];
                s.awvalid[0]      = m.awvalid[gidx_q];
                m.awready[gidx_q] = s.awready[0];
            end
            StWdata: begin
                s.wdata[0]       = m.wdata[gidx_q];
                s.wstrb[0]       = m.wstrb[gidx_q];
                s.wlast[0]       = m.wlast[gidx_q];
                s.wvalid[0]      = m.wvalid[gidx_q];
                m.wready[gidx_q] = s.wready[0];
            end
            StWresp: begin
                m.bid[gidx_q]    = s.bid[0][IDW-1:0];
                m.bresp[gidx_q]  = s.bresp[0];
                m.bvalid[gidx_q] = s.bvalid[0];
                s.bready[0]      = m.bready[gidx_q];
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_axi_sram_arbiter.sv
module tb_axi_sram_arbiter;
    logic       clk;
    logic       rst_n;
    logic [1:0] grant;
    logic       busy;
    logic       prot_err;

    int checks   = 0;
    int failures = 0;

    axi_sram_arbiter_if #(.N(2), .IDW(4)) mi ();
    axi_sram_arbiter_if #(.N(1), .IDW(8)) si ();

    axi_sram_arbiter #(.NM(2), .IDW(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m        (mi),
        .s        (si),
        .grant    (grant),
        .busy     (busy),
        .prot_err (prot_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        int          m;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        int          nbeats;
        bit          toggle;
        logic [7:0]  sarid;
    } rd_vec_t;

    rd_vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req_read(input int m, input logic [3:0] id, input logic [31:0] addr,
                            input logic [3:0] len);
        mi.arid[m]    = id;
        mi.araddr[m]  = addr;
        mi.arlen[m]   = len;
        mi.arsize[m]  = 3'd2;
        mi.arburst[m] = 2'b01;
        mi.arvalid[m] = 1'b1;
    endtask

    task automatic req_write(input int m, input logic [3:0] id, input logic [31:0] addr,
                             input logic [3:0] len);
        mi.awid[m]    = id;
        mi.awaddr[m]  = addr;
        mi.awlen[m]   = len;
        mi.awsize[m]  = 3'd2;
        mi.awburst[m] = 2'b01;
        mi.awvalid[m] = 1'b1;
    endtask

    // Called while idle with a request pending; grant must appear after exactly one edge.
    task automatic expect_grant(input int m, input bit is_rd);
        #1;
        check("idle_busy", busy, 0);
        check("idle_s_arvalid", si.arvalid[0], 0);
        check("idle_s_awvalid", si.awvalid[0], 0);
        tick();
        check("grant", grant, 32'd1 << m);
        check("busy", busy, 1);
        check("s_arvalid_sel", si.arvalid[0], is_rd);
        check("s_awvalid_sel", si.awvalid[0], !is_rd);
    endtask

    task automatic serve_read(input int m, input logic [7:0] exp_id, input logic [31:0] addr,
                              input logic [3:0] len, input int nbeats, input bit toggle,
                              input bit exp_err);
        int b;
        int guard;
        bit ph;
        bit exp_rr;
        si.arready[0] = 1'b1;
        #1;
        check("s_arid", si.arid[0], exp_id);
        check("s_araddr", si.araddr[0], addr);
        check("s_arlen", si.arlen[0], len);
        check("s_arsize", si.arsize[0], 2);
        check("s_arburst", si.arburst[0], 1);
        check("m_arready", mi.arready[m], 1);
        check("m_arready_other", mi.arready[1-m], 0);
        tick();
        si.arready[0] = 1'b0;
        mi.arvalid[m] = 1'b0;
        b = 0;
        guard = 0;
        ph = 1'b1;
        while (b < nbeats && guard < 64) begin
            exp_rr        = toggle ? ph : 1'b1;
            si.rvalid[0]  = 1'b1;
            si.rdata[0]   = 32'hA500_0000 + addr + b;
            si.rlast[0]   = (b == nbeats - 1);
            si.rid[0]     = exp_id;
            si.rresp[0]   = 2'b00;
            mi.rready[m]  = exp_rr;
            #1;
            check("busy_rdata", busy, 1);
            check("m_rvalid", mi.rvalid[m], 1);
            check("m_rvalid_other", mi.rvalid[1-m], 0);
            check("m_rdata", mi.rdata[m], 32'hA500_0000 + addr + b);
            check("m_rid", mi.rid[m], exp_id[3:0]);
            check("m_rlast", mi.rlast[m], (b == nbeats - 1));
            check("s_rready", si.rready[0], exp_rr);
            if (exp_rr) b++;
            ph = !ph;
            guard++;
            tick();
        end
        check("r_beats", b, nbeats);
        si.rvalid[0] = 1'b0;
        si.rlast[0]  = 1'b0;
        mi.rready[m] = 1'b0;
        #1;
        check("busy_end", busy, 0);
        check("grant_end", grant, 0);
        check("prot_err", prot_err, exp_err);
    endtask

    // Performs AW and stop_after W beats; if stop_after < nbeats it returns still in the data phase.
    task automatic serve_write(input int m, input logic [3:0] id, input logic [31:0] addr,
                               input logic [3:0] len, input int nbeats, input int stop_after);
        si.awready[0] = 1'b1;
        #1;
        check("s_awid", si.awid[0], 8'({2'(m), id}));
        check("s_awaddr", si.awaddr[0], addr);
        check("s_awlen", si.awlen[0], len);
        check("m_awready", mi.awready[m], 1);
        tick();
        si.awready[0] = 1'b0;
        mi.awvalid[m] = 1'b0;
        for (int b = 0; b < stop_after; b++) begin
            mi.wvalid[m] = 1'b1;
            mi.wdata[m]  = 32'hDEADBEEF ^ b;
            mi.wstrb[m]  = 4'hF;
            mi.wlast[m]  = (b == nbeats - 1);
            si.wready[0] = 1'b1;
            #1;
            check("s_wvalid", si.wvalid[0], 1);
            check("s_wdata", si.wdata[0], 32'hDEADBEEF ^ b);
            check("s_wstrb", si.wstrb[0], 4'hF);
            check("s_wlast", si.wlast[0], (b == nbeats - 1));
            check("m_wready", mi.wready[m], 1);
            check("m_wready_other", mi.wready[1-m], 0);
            tick();
        end
        if (stop_after < nbeats) return;
        mi.wvalid[m] = 1'b0;
        mi.wlast[m]  = 1'b0;
        si.wready[0] = 1'b0;
        si.bvalid[0] = 1'b1;
        si.bid[0]    = 8'({2'(m), id});
        si.bresp[0]  = 2'b00;
        mi.bready[m] = 1'b1;
        #1;
        check("m_bvalid", mi.bvalid[m], 1);
        check("m_bvalid_other", mi.bvalid[1-m], 0);
        check("m_bid", mi.bid[m], id);
        check("s_bready", si.bready[0], 1);
        check("wresp_s_arvalid", si.arvalid[0], 0);
        check("wresp_s_wvalid", si.wvalid[0], 0);
        tick();
        si.bvalid[0] = 1'b0;
        mi.bready[m] = 1'b0;
        #1;
        check("busy_wend", busy, 0);
        check("grant_wend", grant, 0);
    endtask

    initial begin
        vecs[0] = '{0, 4'h5, 32'h0000_0100, 4'd3, 4, 1'b0, 8'h05};
        vecs[1] = '{1, 4'hA, 32'h0000_0200, 4'd0, 1, 1'b0, 8'h1A};
        vecs[2] = '{0, 4'h3, 32'h0000_0300, 4'd7, 8, 1'b1, 8'h03};
        vecs[3] = '{1, 4'hF, 32'h0000_0044, 4'd1, 2, 1'b1, 8'h1F};

        mi.arid = '0; mi.araddr = '0; mi.arlen = '0; mi.arsize = '0; mi.arburst = '0;
        mi.arvalid = '0; mi.rready = '0;
        mi.awid = '0; mi.awaddr = '0; mi.awlen = '0; mi.awsize = '0; mi.awburst = '0;
        mi.awvalid = '0; mi.wdata = '0; mi.wstrb = '0; mi.wlast = '0; mi.wvalid = '0;
        mi.bready = '0;
        si.arready = '0; si.awready = '0; si.wready = '0;
        si.rid = '0; si.rdata = '0; si.rresp = '0; si.rlast = '0; si.rvalid = '0;
        si.bid = '0; si.bresp = '0; si.bvalid = '0;

        rst_n = 1'b0;
        #1;
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_prot_err", prot_err, 0);
        check("rst_s_arvalid", si.arvalid[0], 0);
        check("rst_m_arready", mi.arready, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Single-master reads, including an 8-beat burst with RREADY toggling.
        foreach (vecs[i]) begin
            req_read(vecs[i].m, vecs[i].id, vecs[i].addr, vecs[i].len);
            expect_grant(vecs[i].m, 1'b1);
            serve_read(vecs[i].m, vecs[i].sarid, vecs[i].addr, vecs[i].len, vecs[i].nbeats,
                       vecs[i].toggle, 1'b0);
        end

        // Collision after M1 was served last: M0 first, then M1.
        req_read(0, 4'h1, 32'h0000_1000, 4'd0);
        req_read(1, 4'h2, 32'h0000_2000, 4'd0);
        expect_grant(0, 1'b1);
        serve_read(0, 8'h01, 32'h0000_1000, 4'd0, 1, 1'b0, 1'b0);
        expect_grant(1, 1'b1);
        serve_read(1, 8'h12, 32'h0000_2000, 4'd0, 1, 1'b0, 1'b0);
        // Lone M0 read leaves rr_last=M0, so the next collision goes to M1.
        req_read(0, 4'h6, 32'h0000_3000, 4'd0);
        expect_grant(0, 1'b1);
        serve_read(0, 8'h06, 32'h0000_3000, 4'd0, 1, 1'b0, 1'b0);
        req_read(0, 4'h7, 32'h0000_4000, 4'd0);
        req_read(1, 4'h8, 32'h0000_5000, 4'd0);
        expect_grant(1, 1'b1);
        serve_read(1, 8'h18, 32'h0000_5000, 4'd0, 1, 1'b0, 1'b0);
        expect_grant(0, 1'b1);
        serve_read(0, 8'h07, 32'h0000_4000, 4'd0, 1, 1'b0, 1'b0);

        // M1 read and write together: read first, then the single-beat write.
        req_read(1, 4'h9, 32'h0000_6000, 4'd1);
        req_write(1, 4'hC, 32'h0000_7000, 4'd0);
        expect_grant(1, 1'b1);
        serve_read(1, 8'h19, 32'h0000_6000, 4'd1, 2, 1'b0, 1'b0);
        expect_grant(1, 1'b0);
        serve_write(1, 4'hC, 32'h0000_7000, 4'd0, 1, 1);

        // Early RLAST on the second beat of a 4-beat burst; the flag must stick.
        req_read(0, 4'h4, 32'h0000_8000, 4'd3);
        expect_grant(0, 1'b1);
        serve_read(0, 8'h04, 32'h0000_8000, 4'd3, 2, 1'b0, 1'b1);
        req_read(1, 4'hB, 32'h0000_9000, 4'd0);
        expect_grant(1, 1'b1);
        serve_read(1, 8'h1B, 32'h0000_9000, 4'd0, 1, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a 4-beat write after 2 beats.
        req_write(0, 4'hD, 32'h0000_A000, 4'd3);
        expect_grant(0, 1'b0);
        serve_write(0, 4'hD, 32'h0000_A000, 4'd3, 4, 2);
        check("pre_rst_m_wready", mi.wready[0], 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_grant", grant, 0);
        check("arst_busy", busy, 0);
        check("arst_prot_err", prot_err, 0);
        check("arst_m_wready", mi.wready, 0);
        check("arst_s_wvalid", si.wvalid[0], 0);
        check("arst_s_awvalid", si.awvalid[0], 0);
        check("arst_s_arvalid", si.arvalid[0], 0);
        check("arst_s_rready", si.rready[0], 0);
        check("arst_s_bready", si.bready[0], 0);
        check("arst_m_rvalid", mi.rvalid, 0);
        check("arst_m_bvalid", mi.bvalid, 0);
        mi.wvalid = '0;
        mi.wlast  = '0;
        si.wready = '0;
        #2;
        rst_n = 1'b1;
        req_read(0, 4'hE, 32'h0000_B000, 4'd0);
        expect_grant(0, 1'b1);
        serve_read(0, 8'h0E, 32'h0000_B000, 4'd0, 1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi_sram_arbiter.md
Name: axi_sram_arbiter

Overview:
- Shares the single-transaction AXI SRAM slave wrapper between NM AXI masters, for example the CPU and the DMA engine.
- Grants exactly one master for one complete transaction:
  - read: AR plus all R beats;
  - write: AW plus all W beats plus B.
- Forwards that master's channels to the slave and routes responses back.
- Round-robin between masters; read before write within one master.

Parameters:
- NM, 2, number of masters (2..4).
- IDW, 4, master-side AXI ID width; slave-side ID width is 8.

Ports:
- CLK  in  1  clock.
- RSTn  in  1  async active-low reset.
- M_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  in  NM x {IDW,32,4,3,2,1}  master read address.
- M_ARREADY  out  NM  per-master read-address ready.
- M_RID/RDATA/RRESP/RLAST/RVALID  out  NM x {IDW,32,2,1,1}  master read data.
- M_RREADY  in  NM  per-master read-data ready.
- M_AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  in  NM x {IDW,32,4,3,2,1}  master write address.
- M_AWREADY  out  NM  per-master write-address ready.
- M_WDATA/WSTRB/WLAST/WVALID  in  NM x {32,4,1,1}  master write data.
- M_WREADY  out  NM  per-master write-data ready.
- M_BID/BRESP/BVALID  out  NM x {IDW,2,1}  master write response.
- M_BREADY  in  NM  per-master write-response ready.
- S_AR*/S_AW*/S_W* (ID 8b)  out  slave request channels, same field widths.
- S_ARREADY/S_AWREADY/S_WREADY  in  1 each  slave request readies.
- S_R*/S_B* (ID 8b)  in  slave response channels.
- S_RREADY/S_BREADY  out  1 each  slave response readies.
- GRANT  out  NM  one-hot granted master, 0 when idle.
- BUSY  out  1  transaction in progress.
- PROT_ERR  out  1  sticky burst-length mismatch flag.

Behaviour:
- Clocking and reset:
  - Single clock CLK; reset RSTn is asynchronous, active-low.
  - On reset: state=IDLE, GRANT=0, BUSY=0, PROT_ERR=0, rr_last=NM-1 (so M0 has priority first), beat counter=0.
  - On reset: every M_*READY, M_RVALID, M_BVALID, S_ARVALID, S_AWVALID, S_WVALID, S_RREADY, S_BREADY is 0.
- FSM states: IDLE, RADDR, RDATA, WADDR, WDATA, WRESP.
- IDLE:
  - req[i] = M_ARVALID[i] | M_AWVALID[i].
  - Winner = first i with req[i], searching from rr_last+1 modulo NM.
  - If the winner has ARVALID: go to RADDR. Otherwise go to WADDR.
  - GRANT is registered on that transition. No master or slave handshake occurs in IDLE, so grant-to-slave latency is 1 cycle.
- RADDR:
  - S_AR* = winner AR fields; S_ARID = {zero pad, idx[1:0], M_ARID}.
  - M_ARREADY[g] = S_ARREADY.
  - On handshake: latch len = ARLEN, clear beat counter, go to RDATA.
- RDATA:
  - M_R*[g] = S_R*, with M_RID = S_RID[IDW-1:0]; S_RREADY = M_RREADY[g].
  - All other masters see RVALID=0.
  - Each R handshake increments the beat counter.
  - On handshake with RLAST: if counter != len, set PROT_ERR. Then rr_last=g, go to IDLE.
- WADDR: forwards AW the same way as RADDR forwards AR. On handshake: latch len, go to WDATA.
- WDATA:
  - S_W* = M_W*[g]; M_WREADY[g] = S_WREADY.
  - Non-granted masters' WREADY = 0.
  - Beat counter counts W handshakes.
  - On WLAST handshake: set PROT_ERR if counter != len, go to WRESP.
- WRESP:
  - M_B*[g] = S_B*; S_BREADY = M_BREADY[g].
  - On handshake: rr_last=g, go to IDLE.
- Beat counter is 4 bits and wraps silently; only the WLAST/RLAST comparison flags errors.
- A non-granted master's VALIDs are held off without ready. They may stay asserted indefinitely; no request is dropped.
- Master asserting ARVALID and AWVALID together: read is served first. Its AW remains pending and competes again at the next IDLE under round-robin.
- Slave-side backpressure is passed through unchanged. No buffering, so zero added latency on R/W/B beats.
- BUSY = (state != IDLE).

Test Plan:
- M0 AR addr 0x100, ARLEN=3, INCR → S_ARID=0x00|M0 ID, 4 R beats to M0 only, last with RLAST; GRANT 01→00; PROT_ERR=0.
- M0 and M1 assert ARVALID on the same cycle after reset → M0 served first, then M1. A repeat collision → M1 first (rr_last=M0).
- M1 raises ARVALID and AWVALID together (AW len 0, WDATA=0xDEADBEEF, WSTRB=0xF) → full read completes, then AW/W/B. BID returns M1's AWID and the bus is otherwise idle.
- Read burst of ARLEN=7 with M_RREADY toggling 1010… → S_RREADY mirrors it; no beat lost or duplicated; 8 beats total.
- Slave returns RLAST on beat 2 of ARLEN=3 → PROT_ERR=1 and sticky; FSM returns to IDLE.
- Assert RSTn=0 mid WDATA, after 2 of 4 beats → all outputs 0 asynchronously; after release a new M0 read is granted in 1 cycle.
